// File: rtl/alu_result_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_result_stage
// Purpose  : Aligns registered AND/NAND/pass-A gate results with their issue,
//            tags them with zero/neg/err flags and buffers them in a
//            two-entry FIFO behind a valid/ready output handshake.
//            Optional per-entry parity storage: define ALU_RESULT_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module alu_result_stage #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] andout,
    input  logic [WIDTH-1:0] nandout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero,
    output logic             out_neg,
    output logic             out_err,
    output logic             out_parity
);

    localparam logic [1:0] c_op_and  = 2'b00;
    localparam logic [1:0] c_op_nand = 2'b01;
    localparam logic [1:0] c_op_pass = 2'b10;
    localparam logic [1:0] c_op_ill  = 2'b11;
    localparam logic [2:0] c_depth   = 3'(DEPTH);

    // Issue alignment: op/a wait one cycle for the gate units to produce results
    logic             r_pend;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_a;

    // Two-entry result buffer
    logic [WIDTH-1:0] r_data [2];
    logic [1:0]       r_zero;
    logic [1:0]       r_neg;
    logic [1:0]       r_err;
    logic             r_wptr;
    logic             r_rptr;
    logic [1:0]       r_count;

    logic             w_issue;
    logic             w_push;
    logic             w_pop;
    logic [WIDTH-1:0] w_result;

    // Readiness depends on registered state only, so out_ready never reaches in_ready
    assign in_ready  = ({1'b0, r_count} + {2'b00, r_pend}) < c_depth;
    assign out_valid = (r_count != 2'd0);
    assign w_issue   = in_valid & in_ready;
    assign w_push    = r_pend;
    assign w_pop     = out_valid & out_ready;

    always_comb begin
        w_result = '0;
        case (r_op)
            c_op_and:  w_result = andout;
            c_op_nand: w_result = nandout;
            c_op_pass: w_result = r_a;
            default:   w_result = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend <= 1'b0;
            r_op   <= 2'b00;
            r_a    <= '0;
        end else begin
            r_pend <= w_issue;
            if (w_issue) begin
                r_op <= op;
                r_a  <= a;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data[0] <= '0;
            r_data[1] <= '0;
            r_zero    <= 2'b00;
            r_neg     <= 2'b00;
            r_err     <= 2'b00;
            r_wptr    <= 1'b0;
            r_rptr    <= 1'b0;
            r_count   <= 2'd0;
        end else begin
            if (w_push) begin
                r_data[r_wptr] <= w_result;
                r_zero[r_wptr] <= (w_result == '0);
                r_neg[r_wptr]  <= w_result[WIDTH-1];
                r_err[r_wptr]  <= (r_op == c_op_ill);
                r_wptr         <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef ALU_RESULT_PARITY_EN
    logic [1:0] r_par;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_par <= 2'b00;
        end else if (w_push) begin
            r_par[r_wptr] <= ^w_result;
        end
    end

    assign out_parity = out_valid & r_par[r_rptr];
`else
    assign out_parity = 1'b0;
`endif

    // Empty buffer presents all-zero outputs so nothing stale is ever visible
    assign out_data = out_valid ? r_data[r_rptr] : '0;
    assign out_zero = out_valid & r_zero[r_rptr];
    assign out_neg  = out_valid & r_neg[r_rptr];
    assign out_err  = out_valid & r_err[r_rptr];

endmodule
`default_nettype wire
